// File: rtl/sp_acp_read_arbiter.sv
// Two-requester round-robin arbiter sharing one ACP read port.
// AR grants are serialized through a HOLD register; an owner FIFO steers returning R bursts.
module sp_acp_read_arbiter #(
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  // requester 0 (SP RX path)
  input  logic                              req0_arvalid,
  output logic                              req0_arready,
  input  logic [31:0]                       req0_araddr,
  input  logic [7:0]                        req0_arlen,
  output logic                              req0_rvalid,
  input  logic                              req0_rready,
  output logic [DATA_WIDTH-1:0]             req0_rdata,
  output logic [1:0]                        req0_rresp,
  output logic                              req0_rlast,
  // requester 1 (SP TX path)
  input  logic                              req1_arvalid,
  output logic                              req1_arready,
  input  logic [31:0]                       req1_araddr,
  input  logic [7:0]                        req1_arlen,
  output logic                              req1_rvalid,
  input  logic                              req1_rready,
  output logic [DATA_WIDTH-1:0]             req1_rdata,
  output logic [1:0]                        req1_rresp,
  output logic                              req1_rlast,
  // ACP master read channels
  output logic                              m_arvalid,
  input  logic                              m_arready,
  output logic [31:0]                       m_araddr,
  output logic [7:0]                        m_arlen,
  input  logic                              m_rvalid,
  output logic                              m_rready,
  input  logic [DATA_WIDTH-1:0]             m_rdata,
  input  logic [1:0]                        m_rresp,
  input  logic                              m_rlast,
  // status
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              unexpected_r
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  typedef enum logic {StIdle, StHold} state_e;

  state_e                     r_state;
  state_e                     w_state_next;
  logic [31:0]                r_araddr;
  logic [7:0]                 r_arlen;
  logic                       r_owner;
  logic                       r_last_grant;
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [PtrW-1:0]            r_wptr;
  logic [PtrW-1:0]            r_rptr;
  logic [CntW-1:0]            r_count;
  logic                       r_unexpected;

  logic w_grant;
  logic w_pick;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_head;

  // On a contest the requester not granted most recently wins.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    req0_arready = 1'b0;
    req1_arready = 1'b0;
    w_pick       = (req0_arvalid && req1_arvalid) ? ~r_last_grant : req1_arvalid;
    case (r_state)
      StIdle: begin
        if (!rst && (req0_arvalid || req1_arvalid) && (r_count < CntMax)) begin
          w_grant      = 1'b1;
          req0_arready = ~w_pick;
          req1_arready = w_pick;
          w_state_next = StHold;
        end
      end
      StHold: begin
        if (m_arready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign m_arvalid = (r_state == StHold) && !rst;
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign w_push    = m_arvalid && m_arready;

  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];

  // Only rvalid/rready are steered; payload fans out to both requesters.
  assign req0_rvalid = !rst && !w_empty && !w_head && m_rvalid;
  assign req1_rvalid = !rst && !w_empty && w_head && m_rvalid;
  assign m_rready    = !rst && !w_empty && (w_head ? req1_rready : req0_rready);
  assign w_pop       = m_rvalid && m_rready && m_rlast;

  assign req0_rdata = m_rdata;
  assign req0_rresp = m_rresp;
  assign req0_rlast = m_rlast;
  assign req1_rdata = m_rdata;
  assign req1_rresp = m_rresp;
  assign req1_rlast = m_rlast;

  assign outstanding  = r_count;
  assign unexpected_r = r_unexpected;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_fifo       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_unexpected <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_araddr <= w_pick ? req1_araddr : req0_araddr;
        r_arlen  <= w_pick ? req1_arlen : req0_arlen;
        r_owner  <= w_pick;
      end
      if (w_push) begin
        r_fifo[r_wptr] <= r_owner;
        r_wptr         <= r_wptr + PtrOne;
        r_last_grant   <= r_owner;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrOne;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntOne;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntOne;
      end
      if (w_empty && m_rvalid) begin
        r_unexpected <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sp_acp_read_arbiter.sv
// Scoreboard bench for sp_acp_read_arbiter: granted ARs and accepted bursts are
// queued by a bench-side round-robin model and compared as the DUT produces them.
module tb_sp_acp_read_arbiter;

  localparam int DW = 128;
  localparam int MO = 4;

  logic          clk, rst;
  logic          req0_arvalid, req0_arready, req0_rvalid, req0_rready, req0_rlast;
  logic [31:0]   req0_araddr;
  logic [7:0]    req0_arlen;
  logic [DW-1:0] req0_rdata;
  logic [1:0]    req0_rresp;
  logic          req1_arvalid, req1_arready, req1_rvalid, req1_rready, req1_rlast;
  logic [31:0]   req1_araddr;
  logic [7:0]    req1_arlen;
  logic [DW-1:0] req1_rdata;
  logic [1:0]    req1_rresp;
  logic          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0]   m_araddr;
  logic [7:0]    m_arlen;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic [2:0]    outstanding;
  logic          unexpected_r;

  int checks   = 0;
  int failures = 0;

  // Model state: last grant plus two scoreboard stages (granted AR, accepted burst).
  logic        model_lg;
  logic        q_ar_own[$];
  logic [31:0] q_ar_addr[$];
  logic [7:0]  q_ar_len[$];
  logic        q_r_own[$];
  logic [31:0] q_r_addr[$];
  logic [7:0]  q_r_len[$];

  sp_acp_read_arbiter #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .req0_arvalid(req0_arvalid), .req0_arready(req0_arready), .req0_araddr(req0_araddr),
    .req0_arlen(req0_arlen), .req0_rvalid(req0_rvalid), .req0_rready(req0_rready),
    .req0_rdata(req0_rdata), .req0_rresp(req0_rresp), .req0_rlast(req0_rlast),
    .req1_arvalid(req1_arvalid), .req1_arready(req1_arready), .req1_araddr(req1_araddr),
    .req1_arlen(req1_arlen), .req1_rvalid(req1_rvalid), .req1_rready(req1_rready),
    .req1_rdata(req1_rdata), .req1_rresp(req1_rresp), .req1_rlast(req1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .outstanding(outstanding), .unexpected_r(unexpected_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] beat_data(input logic [31:0] a, input int b);
    beat_data = {a, 64'h0123_4567_89ab_cdef, 32'(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req0_arvalid = 0; req0_araddr = '0; req0_arlen = '0; req0_rready = 0;
    req1_arvalid = 0; req1_araddr = '0; req1_arlen = '0; req1_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    model_lg = 1'b1;
    q_ar_own.delete(); q_ar_addr.delete(); q_ar_len.delete();
    q_r_own.delete();  q_r_addr.delete();  q_r_len.delete();
  endtask

  task automatic model_grant(input logic w, input logic [31:0] a, input logic [7:0] l);
    q_ar_own.push_back(w); q_ar_addr.push_back(a); q_ar_len.push_back(l);
  endtask

  task automatic model_accept();
    logic w;
    w = q_ar_own.pop_front();
    q_r_own.push_back(w);
    q_r_addr.push_back(q_ar_addr.pop_front());
    q_r_len.push_back(q_ar_len.pop_front());
    model_lg = w;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    req0_arvalid = 1; req1_arvalid = 1; req0_rready = 1; req1_rready = 1;
    m_arready = 1; m_rvalid = 1; m_rlast = 1;
    tick();
    tick();
    settle();
    checks++;
    if ({m_arvalid, m_araddr, m_arlen} !== 41'd0) begin
      failures++;
      $display("FAIL rst_mar: got %h want 0", {m_arvalid, m_araddr, m_arlen});
    end
    checks++;
    if ({outstanding, unexpected_r} !== 4'd0) begin
      failures++;
      $display("FAIL rst_status: got %b want 0000", {outstanding, unexpected_r});
    end
    checks++;
    if ({req0_arready, req1_arready, req0_rvalid, req1_rvalid, m_rready} !== 5'd0) begin
      failures++;
      $display("FAIL rst_hs: got %b want 00000",
               {req0_arready, req1_arready, req0_rvalid, req1_rvalid, m_rready});
    end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_single();
    logic own; logic [31:0] a; logic [7:0] len;
    do_reset();
    req0_arvalid = 1; req0_araddr = 32'h1000_0000; req0_arlen = 8'd3; m_arready = 1;
    settle();
    checks++;
    if ({req1_arready, req0_arready} !== 2'b01) begin
      failures++;
      $display("FAIL s1_grant: got %b want 01", {req1_arready, req0_arready});
    end
    model_grant(1'b0, req0_araddr, req0_arlen);
    tick();
    req0_arvalid = 0; req0_araddr = 32'hDEAD_BEEF; req0_arlen = 8'hFF;
    settle();
    checks++;
    if ({m_arvalid, m_araddr, m_arlen, req0_arready} !== {1'b1, q_ar_addr[0], q_ar_len[0], 1'b0})
    begin
      failures++;
      $display("FAIL s1_hold: got %h want %h", {m_arvalid, m_araddr, m_arlen, req0_arready},
               {1'b1, q_ar_addr[0], q_ar_len[0], 1'b0});
    end
    model_accept();
    tick();
    m_arready = 0;
    settle();
    checks++;
    if ({m_arvalid, outstanding} !== {1'b0, 3'd1}) begin
      failures++;
      $display("FAIL s1_outst: got %b want 0001", {m_arvalid, outstanding});
    end
    own = q_r_own.pop_front(); a = q_r_addr.pop_front(); len = q_r_len.pop_front();
    // Owner stalls for one beat: no rready toward the port.
    m_rvalid = 1; m_rdata = beat_data(a, 0); m_rresp = 2'd0; m_rlast = 0;
    settle();
    checks++;
    if ({req1_rvalid, req0_rvalid, m_rready} !== 3'b010) begin
      failures++;
      $display("FAIL s1_stall: got %b want 010", {req1_rvalid, req0_rvalid, m_rready});
    end
    tick();
    req0_rready = ~own; req1_rready = own;
    for (int b = 0; b <= int'(len); b++) begin
      m_rdata = beat_data(a, b); m_rresp = 2'(b); m_rlast = (b == int'(len));
      settle();
      checks++;
      if ({req1_rvalid, req0_rvalid, m_rready} !== {own, ~own, 1'b1}) begin
        failures++;
        $display("FAIL s1_route beat %0d: got %b want %b", b,
                 {req1_rvalid, req0_rvalid, m_rready}, {own, ~own, 1'b1});
      end
      checks++;
      if ({req0_rdata, req1_rdata, req0_rresp, req0_rlast} !==
          {beat_data(a, b), beat_data(a, b), 2'(b), b == int'(len)}) begin
        failures++;
        $display("FAIL s1_data beat %0d: got %h want %h", b, {req0_rdata, req0_rresp},
                 {beat_data(a, b), 2'(b)});
      end
      tick();
    end
    m_rvalid = 0; m_rlast = 0;
    settle();
    checks++;
    if (outstanding !== 3'd0) begin
      failures++;
      $display("FAIL s1_drain: got %0d want 0", outstanding);
    end
  endtask

  task automatic test_round_robin_fill();
    logic own, w, exp_g; logic [31:0] a; logic [7:0] len;
    logic [3:0] order; int ng; int acc;
    do_reset();
    order = '0; ng = 0; acc = 0;
    m_arready = 1;
    req0_arvalid = 1; req0_araddr = 32'hA000_0000; req0_arlen = 8'd1;
    req1_arvalid = 1; req1_araddr = 32'hB000_0000; req1_arlen = 8'd2;
    for (int cyc = 0; cyc < 20 && acc < 4; cyc++) begin
      settle();
      exp_g = (q_ar_own.size() == 0) && (q_r_own.size() < MO);
      w = ~model_lg;
      checks++;
      if ({req1_arready, req0_arready} !== (exp_g ? {w, ~w} : 2'b00)) begin
        failures++;
        $display("FAIL rr_grant cyc %0d: got %b want %b", cyc, {req1_arready, req0_arready},
                 exp_g ? {w, ~w} : 2'b00);
      end
      if (req0_arready ^ req1_arready) begin
        if (ng < 4) order[ng] = req1_arready;
        ng++;
      end
      if (q_ar_own.size() != 0) begin
        checks++;
        if ({m_arvalid, m_araddr, m_arlen} !== {1'b1, q_ar_addr[0], q_ar_len[0]}) begin
          failures++;
          $display("FAIL rr_mar cyc %0d: got %h want %h", cyc, {m_arvalid, m_araddr, m_arlen},
                   {1'b1, q_ar_addr[0], q_ar_len[0]});
        end
        model_accept();
        acc++;
      end
      if (exp_g) model_grant(w, w ? req1_araddr : req0_araddr, w ? req1_arlen : req0_arlen);
      tick();
      if (exp_g && w) req1_araddr = req1_araddr + 32'h10;
      if (exp_g && !w) req0_araddr = req0_araddr + 32'h10;
    end
    checks++;
    if (order !== 4'b1010 || ng != 4) begin
      failures++;
      $display("FAIL rr_order: got %b (%0d grants) want 1010 (4 grants)", order, ng);
    end
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({outstanding, req1_arready, req0_arready, m_arvalid} !== {3'd4, 3'b000}) begin
        failures++;
        $display("FAIL full_block %0d: got %b want 100000", i,
                 {outstanding, req1_arready, req0_arready, m_arvalid});
      end
      tick();
    end
    // Free exactly one slot; req0 alone is still asking.
    req1_arvalid = 0;
    own = q_r_own.pop_front(); a = q_r_addr.pop_front(); len = q_r_len.pop_front();
    req0_rready = ~own; req1_rready = own;
    for (int b = 0; b <= int'(len); b++) begin
      m_rvalid = 1; m_rdata = beat_data(a, b); m_rlast = (b == int'(len));
      settle();
      checks++;
      if ({req1_rvalid, req0_rvalid, m_rready, req0_arready} !== {own, ~own, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL full_route beat %0d: got %b want %b", b,
                 {req1_rvalid, req0_rvalid, m_rready, req0_arready}, {own, ~own, 1'b1, 1'b0});
      end
      tick();
    end
    m_rvalid = 0; m_rlast = 0;
    settle();
    checks++;
    if ({outstanding, req1_arready, req0_arready} !== {3'd3, 2'b01}) begin
      failures++;
      $display("FAIL freed_grant: got %b want 01101", {outstanding, req1_arready, req0_arready});
    end
    model_grant(1'b0, req0_araddr, req0_arlen);
    tick();
    req0_arvalid = 0;
    settle();
    checks++;
    if ({m_arvalid, m_araddr, m_arlen} !== {1'b1, q_ar_addr[0], q_ar_len[0]}) begin
      failures++;
      $display("FAIL freed_mar: got %h want %h", {m_arvalid, m_araddr, m_arlen},
               {1'b1, q_ar_addr[0], q_ar_len[0]});
    end
    model_accept();
    tick();
    m_arready = 0;
    while (q_r_own.size() > 0) begin
      own = q_r_own.pop_front(); a = q_r_addr.pop_front(); len = q_r_len.pop_front();
      req0_rready = ~own; req1_rready = own;
      for (int b = 0; b <= int'(len); b++) begin
        m_rvalid = 1; m_rdata = beat_data(a, b); m_rlast = (b == int'(len));
        settle();
        checks++;
        if ({req1_rvalid, req0_rvalid, m_rready, req0_rdata} !==
            {own, ~own, 1'b1, beat_data(a, b)}) begin
          failures++;
          $display("FAIL rr_route addr %h beat %0d: got %b want %b", a, b,
                   {req1_rvalid, req0_rvalid, m_rready}, {own, ~own, 1'b1});
        end
        tick();
      end
    end
    m_rvalid = 0; m_rlast = 0;
    settle();
    checks++;
    if (outstanding !== 3'd0) begin
      failures++;
      $display("FAIL rr_drain: got %0d want 0", outstanding);
    end
  endtask

  task automatic test_back_to_back();
    logic own; logic [31:0] a; logic [7:0] len;
    do_reset();
    m_arready = 1;
    req0_arvalid = 1; req0_araddr = 32'hC000_0000; req0_arlen = 8'd1;
    settle();
    model_grant(1'b0, req0_araddr, req0_arlen);
    tick();
    req0_arvalid = 0;
    settle();
    model_accept();
    tick();
    m_arready = 0;
    req1_arvalid = 1; req1_araddr = 32'hD000_0000; req1_arlen = 8'd2;
    settle();
    checks++;
    if ({req1_arready, req0_arready, outstanding} !== {2'b10, 3'd1}) begin
      failures++;
      $display("FAIL b2b_grant: got %b want 10001", {req1_arready, req0_arready, outstanding});
    end
    model_grant(1'b1, req1_araddr, req1_arlen);
    tick();
    // Requester inputs change while the AR is stalled; m_ar* must not follow.
    req1_arvalid = 0; req1_araddr = 32'hFFFF_FFFF; req1_arlen = 8'hFF;
    own = q_r_own.pop_front(); a = q_r_addr.pop_front(); len = q_r_len.pop_front();
    req0_rready = 1; req1_rready = 0;
    m_rvalid = 1; m_rdata = beat_data(a, 0); m_rlast = 0;
    settle();
    checks++;
    if ({m_arvalid, m_araddr, m_arlen, req0_rvalid} !== {1'b1, q_ar_addr[0], q_ar_len[0], ~own})
    begin
      failures++;
      $display("FAIL b2b_stable: got %h want %h", {m_arvalid, m_araddr, m_arlen, req0_rvalid},
               {1'b1, q_ar_addr[0], q_ar_len[0], ~own});
    end
    tick();
    m_rdata = beat_data(a, int'(len)); m_rlast = 1; m_arready = 1;
    settle();
    checks++;
    if ({outstanding, req0_rvalid, m_rready, m_arvalid} !== {3'd1, 3'b111}) begin
      failures++;
      $display("FAIL b2b_coinc: got %b want 001111", {outstanding, req0_rvalid, m_rready, m_arvalid});
    end
    model_accept();
    tick();
    m_arready = 0; m_rvalid = 0; m_rlast = 0;
    settle();
    checks++;
    if ({outstanding, m_arvalid} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_count: got %b want 0010", {outstanding, m_arvalid});
    end
    own = q_r_own.pop_front(); a = q_r_addr.pop_front(); len = q_r_len.pop_front();
    req0_rready = ~own; req1_rready = own;
    for (int b = 0; b <= int'(len); b++) begin
      m_rvalid = 1; m_rdata = beat_data(a, b); m_rlast = (b == int'(len));
      settle();
      checks++;
      if ({req1_rvalid, req0_rvalid, m_rready, req1_rdata} !==
          {own, ~own, 1'b1, beat_data(a, b)}) begin
        failures++;
        $display("FAIL b2b_route beat %0d: got %b want %b", b,
                 {req1_rvalid, req0_rvalid, m_rready}, {own, ~own, 1'b1});
      end
      tick();
    end
    m_rvalid = 0; m_rlast = 0;
    settle();
    checks++;
    if (outstanding !== 3'd0) begin
      failures++;
      $display("FAIL b2b_drain: got %0d want 0", outstanding);
    end
  endtask

  task automatic test_unexpected();
    do_reset();
    req0_rready = 1; req1_rready = 1; m_rvalid = 1; m_rlast = 1;
    settle();
    checks++;
    if ({m_rready, req0_rvalid, req1_rvalid, unexpected_r} !== 4'b0000) begin
      failures++;
      $display("FAIL unexp_same: got %b want 0000", {m_rready, req0_rvalid, req1_rvalid, unexpected_r});
    end
    tick();
    m_rvalid = 0; m_rlast = 0;
    settle();
    checks++;
    if (unexpected_r !== 1'b1) begin
      failures++;
      $display("FAIL unexp_set: got %b want 1", unexpected_r);
    end
    tick(); tick(); tick();
    checks++;
    if (unexpected_r !== 1'b1) begin
      failures++;
      $display("FAIL unexp_sticky: got %b want 1", unexpected_r);
    end
    rst = 1;
    tick();
    rst = 0;
    settle();
    checks++;
    if (unexpected_r !== 1'b0) begin
      failures++;
      $display("FAIL unexp_clear: got %b want 0", unexpected_r);
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    m_arready = 1;
    req1_arvalid = 1; req1_araddr = 32'hE100_0000;
    tick();
    req1_arvalid = 0;
    tick();
    req0_arvalid = 1; req0_araddr = 32'hE000_0000;
    tick();
    req0_arvalid = 0;
    tick();
    // Last accepted grant is now requester 0; park requester 1 in HOLD.
    m_arready = 0;
    req1_arvalid = 1;
    settle();
    checks++;
    if ({req1_arready, req0_arready, outstanding} !== {2'b10, 3'd2}) begin
      failures++;
      $display("FAIL rh_setup: got %b want 10010", {req1_arready, req0_arready, outstanding});
    end
    tick();
    req1_arvalid = 0;
    rst = 1; req0_arvalid = 1; req1_arvalid = 1;
    settle();
    checks++;
    if ({req1_arready, req0_arready} !== 2'b00) begin
      failures++;
      $display("FAIL rh_inrst: got %b want 00", {req1_arready, req0_arready});
    end
    tick();
    rst = 0;
    settle();
    checks++;
    if ({m_arvalid, outstanding, req1_arready, req0_arready} !== {1'b0, 3'd0, 2'b01}) begin
      failures++;
      $display("FAIL rh_after: got %b want 000001",
               {m_arvalid, outstanding, req1_arready, req0_arready});
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_lg = 1'b1;
    test_reset();
    test_single();
    test_round_robin_fill();
    test_back_to_back();
    test_unexpected();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sp_acp_read_arbiter.md
SP_ACP_READ_ARBITER -- requirements
Module: sp_acp_read_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 128, the R-channel data width in bits.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4, the maximum number of in-flight bursts; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have, for each requester n in {0,1} (0 = SP RX path, 1 = SP TX path), the following ports:
- reqn_arvalid, input, 1: AR request;
- reqn_arready, output, 1: request accepted;
- reqn_araddr, input, 32: burst address;
- reqn_arlen, input, 8: AXI beats minus one;
- reqn_rvalid, output, 1: beat valid;
- reqn_rready, input, 1: beat accepted;
- reqn_rdata, output, DATA_WIDTH: beat data;
- reqn_rresp, output, 2: beat response;
- reqn_rlast, output, 1: last beat.
REQ-006 The block SHALL have the following master ports toward the ACP read channels:
- m_arvalid, output, 1;
- m_arready, input, 1;
- m_araddr, output, 32;
- m_arlen, output, 8;
- m_rvalid, input, 1;
- m_rready, output, 1;
- m_rdata, input, DATA_WIDTH;
- m_rresp, input, 2;
- m_rlast, input, 1.
REQ-007 The block SHALL have port outstanding, output, $clog2(MAX_OUTSTANDING)+1 bits: the number of bursts in the owner FIFO.
REQ-008 The block SHALL have port unexpected_r, output, 1: sticky flag, set when a beat arrives with no owner.

Function
REQ-009 The AR path SHALL be a two-state FSM, IDLE and HOLD.
REQ-010 In IDLE, when at least one reqn_arvalid is high and outstanding < MAX_OUTSTANDING, the FSM SHALL grant exactly one requester in the same cycle.
- Granting pulses that requester's reqn_arready for one cycle.
- The request's address and length are latched into the AR register.
- The grant owner is latched.
- The FSM moves to HOLD.
REQ-011 Arbitration SHALL be round-robin:
- if only one requester is valid, it wins;
- if both are valid, the requester not granted most recently wins;
- last_grant resets to 1, so requester 0 wins the first contest.
REQ-012 reqn_arready SHALL be 0 in HOLD, in IDLE when outstanding = MAX_OUTSTANDING, and in reset.
REQ-013 In HOLD, m_arvalid SHALL be 1 and m_araddr/m_arlen SHALL equal the latched values, stable until m_arready.
REQ-014 On m_arvalid && m_arready, the block SHALL:
- push the latched owner into the owner FIFO;
- update last_grant;
- return to IDLE (so minimum AR spacing is 2 cycles).
REQ-015 m_arvalid SHALL be 0 in IDLE.
REQ-016 When the owner FIFO is non-empty, with head owner h:
- reqh_rvalid = m_rvalid;
- m_rready = reqh_rready;
- the other requester's rvalid = 0.
REQ-017 rdata, rresp and rlast SHALL be driven from the m_r* inputs to both requesters combinationally (zero-latency pass-through); only rvalid is gated.
REQ-018 The FIFO head SHALL be popped on m_rvalid && m_rready && m_rlast.
REQ-019 If a push and a pop occur in the same cycle, outstanding SHALL remain unchanged and FIFO order SHALL be preserved.
REQ-020 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-021 When the owner FIFO is empty:
- m_rready = 0 and both reqn_rvalid = 0;
- if m_rvalid is 1, unexpected_r SHALL be set on the next edge and held until rst.
REQ-022 Beats of a burst SHALL never be routed to a requester other than the FIFO head owner, regardless of new AR grants.
REQ-023 reqn_araddr and reqn_arlen SHALL be sampled only in the grant cycle; later changes SHALL NOT affect m_ar*.

Reset
REQ-024 While rst is high, and on the first edge after it, the block SHALL hold:
- state = IDLE;
- m_arvalid = 0, m_araddr = 0, m_arlen = 0;
- FIFO empty, outstanding = 0;
- last_grant = 1;
- unexpected_r = 0;
- all reqn_arready = 0 and reqn_rvalid = 0.
REQ-025 Reset asserted mid-burst or during HOLD SHALL abandon all in-flight state without completing handshakes; the surrounding system resets the ACP port together with this block.

Verification
REQ-026 Scenario 1:
- Stimulus: req0 only, araddr=0x1000_0000, arlen=3, m_arready tied 1, m_rready from req0.
- Required response: req0_arready pulses in cycle T; m_arvalid is high in T+1 with 0x1000_0000/3; outstanding=1; 4 beats reach req0; req1_rvalid stays 0; outstanding returns to 0 after rlast.
REQ-027 Scenario 2:
- Stimulus: both requesters hold arvalid continuously after reset.
- Required response: grant order is 0,1,0,1; FIFO order matches; R bursts are returned in that order.
REQ-028 Scenario 3:
- Stimulus: MAX_OUTSTANDING=4, m_arready=1, no R beats.
- Required response: after 4 accepted bursts, outstanding=4 and both arready stay 0; one rlast frees a slot and the next grant follows.
REQ-029 Scenario 4:
- Stimulus: the rlast handshake of burst A coincides with the m_arready handshake of burst B.
- Required response: outstanding is unchanged; B's beats route to B's owner.
REQ-030 Scenario 5:
- Stimulus: m_rvalid=1 with the FIFO empty.
- Required response: m_rready=0; unexpected_r=1 from the next cycle until rst.
REQ-031 Scenario 6:
- Stimulus: rst asserted in HOLD with 2 bursts outstanding.
- Required response: next cycle m_arvalid=0, outstanding=0, and last_grant is reset so requester 0 wins the next contest.
